// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and pipeline control bundle for the MIPS back end
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic memToReg;
    logic regWrite;
    logic memWrite;
    logic memRead;
  } mem_ctrl_t;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, synchronous write, combinational read, no reset
module data_memory
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         wrEn,
  input  logic [$clog2(MEM_WORDS)-1:0] index,
  input  logic [WORD_W-1:0]            wrData,
  output logic [WORD_W-1:0]            rdData
);
  logic [WORD_W-1:0] mem [MEM_WORDS];
  // store lands on the edge that ends the MEM stage; contents survive reset
  always_ff @(posedge clk) begin
    if (wrEn) mem[index] <= wrData;
  end
  assign rdData = mem[index];
endmodule

// File: rtl/mem_wb_backend.sv
// mem_wb_backend: EX/MEM register, data memory, MEM/WB register and write-back mux
module mem_wb_backend
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memToRegEx,
  input  logic                  regWriteEx,
  input  logic                  memWriteEx,
  input  logic                  memReadEx,
  input  logic [WORD_W-1:0]     aluResultEx,
  input  logic [WORD_W-1:0]     storeDataEx,
  input  logic [REG_ADDR_W-1:0] writeRegisterEx,
  output logic                  regWriteMem,
  output logic [REG_ADDR_W-1:0] writeRegisterMem,
  output logic [WORD_W-1:0]     aluResultMem,
  output logic                  regWriteWb,
  output logic [REG_ADDR_W-1:0] writeRegisterWb,
  output logic [WORD_W-1:0]     writeData
);
  localparam int AW = $clog2(MEM_WORDS);
  mem_ctrl_t             ctrlMem;
  logic [WORD_W-1:0]     storeDataMem;
  logic [WORD_W-1:0]     readDataMem;
  logic                  memToRegWb;
  logic                  regWriteRawWb;
  logic [WORD_W-1:0]     aluResultWb;
  logic [WORD_W-1:0]     readDataWb;
  // EX/MEM register: free-running capture, bubbles arrive as zero control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlMem          <= '0;
      aluResultMem     <= '0;
      storeDataMem     <= '0;
      writeRegisterMem <= '0;
    end else begin
      ctrlMem          <= '{memToReg: memToRegEx, regWrite: regWriteEx,
                            memWrite: memWriteEx, memRead: memReadEx};
      aluResultMem     <= aluResultEx;
      storeDataMem     <= storeDataEx;
      writeRegisterMem <= writeRegisterEx;
    end
  end
  assign regWriteMem = ctrlMem.regWrite;
  data_memory #(.MEM_WORDS(MEM_WORDS)) dataMem (
    .clk    (clk),
    .wrEn   (ctrlMem.memWrite),
    .index  (aluResultMem[AW+1:2]),
    .wrData (storeDataMem),
    .rdData (readDataMem)
  );
  // MEM/WB register: read data is the pre-write word when load and store coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memToRegWb      <= 1'b0;
      regWriteRawWb   <= 1'b0;
      writeRegisterWb <= '0;
      aluResultWb     <= '0;
      readDataWb      <= '0;
    end else begin
      memToRegWb      <= ctrlMem.memToReg;
      regWriteRawWb   <= ctrlMem.regWrite;
      writeRegisterWb <= writeRegisterMem;
      aluResultWb     <= aluResultMem;
      readDataWb      <= readDataMem;
    end
  end
  // write-back mux and $0 guard
  always_comb begin
    writeData  = memToRegWb ? readDataWb : aluResultWb;
    regWriteWb = regWriteRawWb && (writeRegisterWb != '0);
  end
endmodule

// File: tb/tb_mem_wb_backend.sv
// tb_mem_wb_backend: directed self-checking bench for mem_wb_backend
module tb_mem_wb_backend;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memToRegEx = 1'b0, regWriteEx = 1'b0, memWriteEx = 1'b0, memReadEx = 1'b0;
  logic [31:0] aluResultEx = '0, storeDataEx = '0;
  logic [4:0]  writeRegisterEx = '0;
  logic        regWriteMem, regWriteWb;
  logic [4:0]  writeRegisterMem, writeRegisterWb;
  logic [31:0] aluResultMem, writeData;
  int nCompared = 0;
  int nMismatched = 0;

  mem_wb_backend #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .memToRegEx(memToRegEx), .regWriteEx(regWriteEx), .memWriteEx(memWriteEx), .memReadEx(memReadEx),
    .aluResultEx(aluResultEx), .storeDataEx(storeDataEx), .writeRegisterEx(writeRegisterEx),
    .regWriteMem(regWriteMem), .writeRegisterMem(writeRegisterMem), .aluResultMem(aluResultMem),
    .regWriteWb(regWriteWb), .writeRegisterWb(writeRegisterWb), .writeData(writeData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic m2r, rw, mw, mr, input logic [31:0] alu, sd, input logic [4:0] wr);
    memToRegEx = m2r; regWriteEx = rw; memWriteEx = mw; memReadEx = mr;
    aluResultEx = alu; storeDataEx = sd; writeRegisterEx = wr;
  endtask

  task automatic issue(input logic m2r, rw, mw, mr, input logic [31:0] alu, sd, input logic [4:0] wr);
    drive(m2r, rw, mw, mr, alu, sd, wr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bubble();
    issue(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".regWriteMem"}, {31'b0, regWriteMem}, 32'h0);
    check({tag, ".writeRegisterMem"}, {27'b0, writeRegisterMem}, 32'h0);
    check({tag, ".aluResultMem"}, aluResultMem, 32'h0);
    check({tag, ".regWriteWb"}, {31'b0, regWriteWb}, 32'h0);
    check({tag, ".writeRegisterWb"}, {27'b0, writeRegisterWb}, 32'h0);
    check({tag, ".writeData"}, writeData, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
      @(posedge clk);
      #1 checkAllZero("rstHold");
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("rstRelease");
    issue(0, 0, 1, 0, 32'h80, 32'h0, 5'd0);
    issue(0, 0, 1, 0, 32'h0, 32'h0, 5'd0);
    issue(0, 1, 0, 0, 32'h11, 32'h0, 5'd8);
    check("rtype.regWriteMem", {31'b0, regWriteMem}, 32'h1);
    check("rtype.writeRegisterMem", {27'b0, writeRegisterMem}, 32'd8);
    check("rtype.aluResultMem", aluResultMem, 32'h11);
    check("rtype.wbEarly", {31'b0, regWriteWb}, 32'h0);
    bubble();
    check("rtype.regWriteWb", {31'b0, regWriteWb}, 32'h1);
    check("rtype.writeRegisterWb", {27'b0, writeRegisterWb}, 32'd8);
    check("rtype.writeData", writeData, 32'h11);
    issue(0, 0, 1, 0, 32'h40, 32'hDEADBEEF, 5'd0);
    issue(1, 1, 0, 1, 32'h40, 32'h0, 5'd9);
    bubble();
    check("stld.writeData", writeData, 32'hDEADBEEF);
    check("stld.writeRegisterWb", {27'b0, writeRegisterWb}, 32'd9);
    check("stld.regWriteWb", {31'b0, regWriteWb}, 32'h1);
    issue(0, 0, 1, 0, 32'h0000_0403, 32'h1234, 5'd0);
    issue(1, 1, 0, 1, 32'h3, 32'h0, 5'd10);
    bubble();
    check("wrap.writeData", writeData, 32'h1234);
    issue(0, 0, 1, 0, 32'h8, 32'h5555, 5'd0);
    issue(1, 1, 1, 1, 32'h8, 32'hAAAA, 5'd11);
    issue(1, 1, 0, 1, 32'h8, 32'h0, 5'd11);
    check("rdwr.preWrite", writeData, 32'h5555);
    bubble();
    check("rdwr.postWrite", writeData, 32'hAAAA);
    issue(0, 0, 1, 0, 32'hC, 32'h111, 5'd0);
    issue(0, 0, 1, 0, 32'hC, 32'h222, 5'd0);
    issue(1, 1, 0, 1, 32'hC, 32'h0, 5'd12);
    bubble();
    check("lastStore.writeData", writeData, 32'h222);
    issue(0, 1, 0, 0, 32'h55, 32'h0, 5'd0);
    check("zeroReg.regWriteMem", {31'b0, regWriteMem}, 32'h1);
    bubble();
    check("zeroReg.regWriteWb", {31'b0, regWriteWb}, 32'h0);
    check("zeroReg.writeData", writeData, 32'h55);
    bubble();
    check("zeroReg.regWriteWbLater", {31'b0, regWriteWb}, 32'h0);
    drive(0, 0, 1, 0, 32'h80, 32'hCAFEF00D, 5'd0);
    @(posedge clk);
    #1 check("midRst.inFlight", aluResultMem, 32'h80);
    reset = 1'b0;
    #1 checkAllZero("midRst");
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1 checkAllZero("midRstHeld");
    @(negedge clk);
    reset = 1'b1;
    issue(1, 1, 0, 1, 32'h80, 32'h0, 5'd12);
    bubble();
    check("midRst.loadBack", writeData, 32'h0);
    check("midRst.loadReg", {27'b0, writeRegisterWb}, 32'd12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
